// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared state encodings, segment patterns and helpers
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_SUB  = 2'd1,
    C_DONE = 2'd2
  } conv_state_e;

  typedef enum logic [1:0] {
    BLANK_U = 2'd0,
    SHOW_U  = 2'd1,
    BLANK_T = 2'd2,
    SHOW_T  = 2'd3
  } scan_state_e;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_TENS  = 2'b01;
  localparam logic [1:0] SEL_UNITS = 2'b10;

  localparam logic [6:0] VALUE_MAX = 7'd99;

  function automatic logic [6:0] sat_value(input logic [6:0] v);
    return (v > VALUE_MAX) ? VALUE_MAX : v;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - setpoint load handshake and display drive bundle
interface seg_scan_ctrl_if;
  logic [6:0] value;
  logic       value_load;
  logic       load_ready;
  logic       over_range;
  logic       frame_tick;
  logic [6:0] seg;
  logic [1:0] led_select;

  modport master (
    output value, value_load,
    input  load_ready, over_range, frame_tick, seg, led_select
  );

  modport slave (
    input  value, value_load,
    output load_ready, over_range, frame_tick, seg, led_select
  );
endinterface

// File: rtl/seg_scan_ctrl_seg7_decode.sv
// rtl/seg_scan_ctrl_seg7_decode.sv - 4-bit digit to 7-segment pattern, combinational
module seg7_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 2-digit multiplexed 7-segment scan controller with binary-to-BCD loader
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 13500,
  parameter int unsigned BLANK_CYC = 64,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  conv_state_e conv_q, conv_d;
  logic [6:0]  rem_q, rem_d;
  logic [3:0]  tens_acc_q, tens_acc_d;
  logic        over_range_q, over_range_d;
  logic        load_ready_q, load_ready_d;
  logic        pending_q, pending_d;
  logic [3:0]  pend_t_q, pend_t_d;
  logic [3:0]  pend_u_q, pend_u_d;

  scan_state_e scan_q, scan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        frame_tick_q, frame_tick_d;
  logic [3:0]  shown_t_q, shown_t_d;
  logic [3:0]  shown_u_q, shown_u_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  sel_q, sel_d;

  logic        enter_bu;
  logic [3:0]  dec_digit;
  logic [6:0]  dec_seg;

  // Sequential subtract-by-10: one tens step per cycle, then hand off to the scan side
  always_comb begin
    conv_d       = conv_q;
    rem_d        = rem_q;
    tens_acc_d   = tens_acc_q;
    over_range_d = over_range_q;
    load_ready_d = load_ready_q;
    pend_t_d     = pend_t_q;
    pend_u_d     = pend_u_q;
    case (conv_q)
      C_IDLE: begin
        if (bus.value_load && load_ready_q) begin
          rem_d        = sat_value(bus.value);
          tens_acc_d   = 4'd0;
          over_range_d = (bus.value > VALUE_MAX);
          load_ready_d = 1'b0;
          conv_d       = C_SUB;
        end
      end
      C_SUB: begin
        if (rem_q >= 7'd10) begin
          rem_d      = rem_q - 7'd10;
          tens_acc_d = tens_acc_q + 4'd1;
        end else begin
          conv_d = C_DONE;
        end
      end
      C_DONE: begin
        pend_t_d     = tens_acc_q;
        pend_u_d     = rem_q[3:0];
        load_ready_d = 1'b1;
        conv_d       = C_IDLE;
      end
      default: conv_d = C_IDLE;
    endcase
  end

  always_comb begin
    scan_d   = scan_q;
    cnt_d    = cnt_q + CNT_W'(1);
    enter_bu = 1'b0;
    case (scan_q)
      BLANK_U: if (cnt_q == BLANK_LAST) scan_d = SHOW_U;
      SHOW_U: begin
        if (cnt_q == SLOT_LAST) begin
          scan_d = BLANK_T;
          cnt_d  = '0;
        end
      end
      BLANK_T: if (cnt_q == BLANK_LAST) scan_d = SHOW_T;
      SHOW_T: begin
        if (cnt_q == SLOT_LAST) begin
          scan_d   = BLANK_U;
          cnt_d    = '0;
          enter_bu = 1'b1;
        end
      end
      default: begin
        scan_d = BLANK_U;
        cnt_d  = '0;
      end
    endcase
  end

  // A C_DONE landing on the frame edge sees pending_q still clear, so it waits a frame
  always_comb begin
    frame_tick_d = enter_bu;
    shown_t_d    = shown_t_q;
    shown_u_d    = shown_u_q;
    pending_d    = pending_q;
    if (enter_bu && pending_q) begin
      shown_t_d = pend_t_q;
      shown_u_d = pend_u_q;
      pending_d = 1'b0;
    end
    if (conv_q == C_DONE) pending_d = 1'b1;
  end

  assign dec_digit = (scan_q == SHOW_T) ? shown_t_q : shown_u_q;

  seg7_decode u_decode (
    .digit_i (dec_digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    sel_d = SEL_NONE;
    seg_d = SEG_BLANK;
    case (scan_q)
      SHOW_U: begin
        sel_d = SEL_UNITS;
        seg_d = dec_seg;
      end
      SHOW_T: begin
        if (!(LZ_BLANK && (shown_t_q == 4'd0))) begin
          sel_d = SEL_TENS;
          seg_d = dec_seg;
        end
      end
      default: begin
        sel_d = SEL_NONE;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q       <= C_IDLE;
      rem_q        <= '0;
      tens_acc_q   <= '0;
      over_range_q <= 1'b0;
      load_ready_q <= 1'b1;
      pending_q    <= 1'b0;
      pend_t_q     <= '0;
      pend_u_q     <= '0;
      scan_q       <= BLANK_U;
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      shown_t_q    <= '0;
      shown_u_q    <= '0;
      seg_q        <= SEG_BLANK;
      sel_q        <= SEL_NONE;
    end else begin
      conv_q       <= conv_d;
      rem_q        <= rem_d;
      tens_acc_q   <= tens_acc_d;
      over_range_q <= over_range_d;
      load_ready_q <= load_ready_d;
      pending_q    <= pending_d;
      pend_t_q     <= pend_t_d;
      pend_u_q     <= pend_u_d;
      scan_q       <= scan_d;
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      shown_t_q    <= shown_t_d;
      shown_u_q    <= shown_u_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.over_range = over_range_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.seg        = seg_q;
  assign bus.led_select = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 16;
  localparam int BLANK_CYC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus();
  seg_scan_ctrl_if bus_nz();

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_BLANK(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_BLANK(1'b0)) u_dut_nz (
    .clk (clk),
    .rst (rst),
    .bus (bus_nz)
  );

  typedef struct {
    logic [6:0] u_seg;
    logic       t_vis;
    logic [6:0] t_seg;
    logic       armed;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [6:0] u, input logic tv, input logic [6:0] t);
    exp_t e;
    e.u_seg = u;
    e.t_vis = tv;
    e.t_seg = t;
    e.armed = 1'b0;
    e.id    = id;
    exp_q.push_back(e);
  endtask

  // Entry armed at the next frame tick; if the load finished on a tick cycle, commit slips a frame
  task automatic push_after_load(input int id, input logic [6:0] u, input logic tv, input logic [6:0] t);
    if (bus.frame_tick) tick();
    push_exp(id, u, tv, t);
  endtask

  task automatic load_value(input logic [6:0] v, output int low_cycles);
    bus.value      = v;
    bus.value_load = 1'b1;
    tick();
    bus.value_load = 1'b0;
    low_cycles = 0;
    while (!bus.load_ready && low_cycles < 50) begin
      low_cycles++;
      tick();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: collects one frame of display activity between frame ticks
  logic       u_seen, t_seen, inv_bad;
  logic [6:0] u_obs, t_obs;
  logic [1:0] prev_sel;
  int         zrun;

  always @(negedge clk) begin
    if (rst) begin
      u_seen   = 1'b0;
      t_seen   = 1'b0;
      inv_bad  = 1'b0;
      u_obs    = 7'h00;
      t_obs    = 7'h00;
      prev_sel = 2'b00;
      zrun     = 1000;
    end else begin
      if (bus.led_select == 2'b11) inv_bad = 1'b1;
      if (bus.led_select == 2'b00 && bus.seg != 7'h00) inv_bad = 1'b1;
      if (bus.led_select != 2'b00) begin
        if (prev_sel == 2'b00) begin
          if (zrun < BLANK_CYC) inv_bad = 1'b1;
        end else if (prev_sel != bus.led_select) begin
          inv_bad = 1'b1;
        end
        zrun = 0;
      end else begin
        zrun++;
      end
      if (bus.led_select == 2'b10) begin
        if (u_seen && bus.seg != u_obs) inv_bad = 1'b1;
        u_seen = 1'b1;
        u_obs  = bus.seg;
      end
      if (bus.led_select == 2'b01) begin
        if (t_seen && bus.seg != t_obs) inv_bad = 1'b1;
        t_seen = 1'b1;
        t_obs  = bus.seg;
      end
      prev_sel = bus.led_select;
      if (bus.frame_tick) begin
        if (exp_q.size() > 0 && exp_q[0].armed) begin
          mon_e = exp_q.pop_front();
          chk($sformatf("f%0d_units_seen", mon_e.id), u_seen, 1);
          chk($sformatf("f%0d_units_seg", mon_e.id), u_obs, mon_e.u_seg);
          chk($sformatf("f%0d_tens_visible", mon_e.id), t_seen, mon_e.t_vis);
          if (mon_e.t_vis) chk($sformatf("f%0d_tens_seg", mon_e.id), t_obs, mon_e.t_seg);
          chk($sformatf("f%0d_scan_rules", mon_e.id), inv_bad, 0);
        end
        if (exp_q.size() > 0 && !exp_q[0].armed) exp_q[0].armed = 1'b1;
        u_seen  = 1'b0;
        t_seen  = 1'b0;
        inv_bad = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int n;
    bus.value         = 7'd0;
    bus.value_load    = 1'b0;
    bus_nz.value      = 7'd0;
    bus_nz.value_load = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_sel", bus.led_select, 2'b00);
    chk("rst_seg", bus.seg, 7'h00);
    chk("rst_load_ready", bus.load_ready, 1);
    chk("rst_over_range", bus.over_range, 0);
    chk("rst_frame_tick", bus.frame_tick, 0);
    rst = 1'b0;
    push_exp(1, 7'h3F, 1'b0, 7'h00);
    n = 0;
    while (bus.led_select != 2'b10 && n < 40) begin tick(); n++; end
    chk("first_units_seg", bus.seg, 7'h3F);
    drain("drain_reset_frame");

    load_value(7'd57, low);
    chk("load57_busy_cycles", low, 7);
    push_after_load(2, 7'h07, 1'b1, 7'h6D);
    drain("drain_57");

    load_value(7'd120, low);
    chk("load120_busy_cycles", low, 11);
    chk("load120_over_range", bus.over_range, 1);
    push_after_load(3, 7'h6F, 1'b1, 7'h6F);
    drain("drain_120");

    load_value(7'd5, low);
    chk("load5_busy_cycles", low, 2);
    chk("load5_over_range", bus.over_range, 0);
    push_after_load(4, 7'h6D, 1'b0, 7'h00);
    drain("drain_5");

    bus.value      = 7'd42;
    bus.value_load = 1'b1;
    tick();
    bus.value      = 7'd13;
    tick();
    bus.value_load = 1'b0;
    low = 1;
    while (!bus.load_ready && low < 50) begin low++; tick(); end
    chk("load42_busy_cycles", low, 6);
    push_after_load(5, 7'h5B, 1'b1, 7'h66);
    drain("drain_42");

    n = 0;
    while (!bus.frame_tick && n < 100) begin tick(); n++; end
    repeat (21) tick();
    load_value(7'd88, low);
    chk("load88_busy_cycles", low, 10);
    chk("load88_done_on_frame_edge", bus.frame_tick, 1);
    push_exp(6, 7'h5B, 1'b1, 7'h66);
    push_exp(7, 7'h7F, 1'b1, 7'h7F);
    drain("drain_88");

    n = 0;
    while (bus.led_select != 2'b01 && n < 40) begin tick(); n++; end
    chk("pre_rst_tens_visible", bus.led_select, 2'b01);
    rst = 1'b1;
    tick();
    chk("midframe_rst_sel", bus.led_select, 2'b00);
    chk("midframe_rst_seg", bus.seg, 7'h00);
    tick();
    rst = 1'b0;
    n = 0;
    while (bus_nz.led_select != 2'b01 && n < 40) begin tick(); n++; end
    chk("nolz_tens_sel", bus_nz.led_select, 2'b01);
    chk("nolz_tens_seg", bus_nz.seg, 7'h3F);

    bus.value      = 7'd31;
    bus.value_load = 1'b1;
    tick();
    bus.value_load = 1'b0;
    tick();
    chk("conv31_busy", bus.load_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("conv_rst_load_ready", bus.load_ready, 1);
    push_exp(8, 7'h3F, 1'b0, 7'h00);
    drain("drain_conv_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
